// File: rtl/mcmc_lfsr_bitgen.sv
// Dual Fibonacci-LFSR random bit source feeding the MCMC registered XOR stage.
// Two LFSRs advance together while running; bursts of BURST_LEN bits end with
// a DONE pulse aligned to the last BIT_VALID. Seeds can be loaded while idle.
module mcmc_lfsr_bitgen #(
  parameter int              WIDTH  = 32,
  parameter logic [WIDTH-1:0] TAPS_A = 32'h80200003,
  parameter logic [WIDTH-1:0] TAPS_B = 32'h80000057,
  parameter logic [WIDTH-1:0] SEED_A = 32'h00000001,
  parameter logic [WIDTH-1:0] SEED_B = 32'hACE1ACE1,
  parameter int              CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic             EN,
  input  logic [CNT_W-1:0] BURST_LEN,
  input  logic             SEED_VALID,
  output logic             SEED_READY,
  input  logic             SEED_SEL,
  input  logic [WIDTH-1:0] SEED_DATA,
  output logic             BIT_A,
  output logic             BIT_B,
  output logic             BIT_VALID,
  output logic             DONE,
  output logic             BUSY,
  output logic             SEED_ERR
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   lfsr_a_r, lfsr_b_r;
  logic [CNT_W-1:0]   cnt_r, len_r, cnt_next_s;
  logic               bit_a_r, bit_b_r, bit_valid_r, done_r, seed_err_r;
  logic               advance_s, last_s, start_s, seed_wr_s, seed_zero_s;

  // Feedback bit: parity of the tapped LFSR positions.
  function automatic logic tap_parity(input logic [WIDTH-1:0] v,
                                      input logic [WIDTH-1:0] taps);
    return ^(v & taps);
  endfunction

  // Substitute the default seed when an all-zero (lock-up) seed is offered.
  function automatic logic [WIDTH-1:0] safe_seed(input logic [WIDTH-1:0] data,
                                                 input logic [WIDTH-1:0] dflt);
    return (data == {WIDTH{1'b0}}) ? dflt : data;
  endfunction

  // Control decode: advance qualification, burst-final detection, seed/start acceptance.
  always_comb begin
    advance_s   = (state_r == ST_RUN) && EN && !STOP;
    cnt_next_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    last_s      = advance_s && (len_r != {CNT_W{1'b0}}) && (cnt_next_s == len_r);
    start_s     = (state_r == ST_IDLE) && START && !STOP;
    seed_wr_s   = (state_r == ST_IDLE) && SEED_VALID;
    seed_zero_s = (SEED_DATA == {WIDTH{1'b0}});
  end

  // Next-state logic: STOP always wins while running, burst end returns to idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_RUN;
        else         state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (STOP)        state_s = ST_IDLE;
        else if (last_s) state_s = ST_IDLE;
        else             state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // LFSR shift on advance; seed load only possible while idle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lfsr_a_r <= SEED_A;
      lfsr_b_r <= SEED_B;
    end else if (advance_s) begin
      lfsr_a_r <= {lfsr_a_r[WIDTH-2:0], tap_parity(lfsr_a_r, TAPS_A)};
      lfsr_b_r <= {lfsr_b_r[WIDTH-2:0], tap_parity(lfsr_b_r, TAPS_B)};
    end else if (seed_wr_s) begin
      if (SEED_SEL) lfsr_b_r <= safe_seed(SEED_DATA, SEED_B);
      else          lfsr_a_r <= safe_seed(SEED_DATA, SEED_A);
    end
  end

  // Burst length capture on start and per-advance bit counter (wraps when free-running).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= {CNT_W{1'b0}};
      len_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      cnt_r <= {CNT_W{1'b0}};
      len_r <= BURST_LEN;
    end else if (advance_s) begin
      cnt_r <= cnt_next_s;
    end
  end

  // Registered output bits, valid strobe and burst-done pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_a_r     <= 1'b0;
      bit_b_r     <= 1'b0;
      bit_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      bit_valid_r <= advance_s;
      done_r      <= last_s;
      if (advance_s) begin
        bit_a_r <= lfsr_a_r[WIDTH-1];
        bit_b_r <= lfsr_b_r[WIDTH-1];
      end
    end
  end

  // Sticky flag recording any rejected zero seed.
  always_ff @(posedge CLK) begin
    if (RESET)                         seed_err_r <= 1'b0;
    else if (seed_wr_s && seed_zero_s) seed_err_r <= 1'b1;
  end

  assign BIT_A      = bit_a_r;
  assign BIT_B      = bit_b_r;
  assign BIT_VALID  = bit_valid_r;
  assign DONE       = done_r;
  assign SEED_ERR   = seed_err_r;
  assign BUSY       = (state_r == ST_RUN);
  assign SEED_READY = (state_r == ST_IDLE);

endmodule

// File: tb/tb_mcmc_lfsr_bitgen.sv
// Bench for mcmc_lfsr_bitgen: directed scenarios plus random traffic, every
// cycle compared against a cycle-level behavioural model of the generator.
module tb_mcmc_lfsr_bitgen;

  localparam int          WIDTH  = 32;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] TAPS_A = 32'h80200003;
  localparam logic [31:0] TAPS_B = 32'h80000057;
  localparam logic [31:0] SEED_A = 32'h00000001;
  localparam logic [31:0] SEED_B = 32'hACE1ACE1;

  logic CLK = 1'b0;
  logic RESET, START, STOP, EN, SEED_VALID, SEED_SEL;
  logic [CNT_W-1:0] BURST_LEN;
  logic [WIDTH-1:0] SEED_DATA;
  logic SEED_READY, BIT_A, BIT_B, BIT_VALID, DONE, BUSY, SEED_ERR;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit          m_run;
  logic [31:0] m_a, m_b;
  int          m_cnt, m_len;
  bit          m_bita, m_bitb, m_valid, m_done, m_err;

  always #5 CLK = ~CLK;

  mcmc_lfsr_bitgen #(
    .WIDTH(WIDTH), .TAPS_A(TAPS_A), .TAPS_B(TAPS_B),
    .SEED_A(SEED_A), .SEED_B(SEED_B), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .EN(EN),
    .BURST_LEN(BURST_LEN), .SEED_VALID(SEED_VALID), .SEED_READY(SEED_READY),
    .SEED_SEL(SEED_SEL), .SEED_DATA(SEED_DATA), .BIT_A(BIT_A), .BIT_B(BIT_B),
    .BIT_VALID(BIT_VALID), .DONE(DONE), .BUSY(BUSY), .SEED_ERR(SEED_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next LFSR value: shift left, feedback = odd number of set tapped bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v, input logic [31:0] t);
    int ones;
    ones = $countones(v & t);
    return (v << 1) | 32'(ones % 2);
  endfunction

  task automatic model_reset();
    m_run = 0; m_a = SEED_A; m_b = SEED_B; m_cnt = 0; m_len = 0;
    m_bita = 0; m_bitb = 0; m_valid = 0; m_done = 0; m_err = 0;
  endtask

  // One clock: update model from current inputs, then compare all outputs.
  task automatic step(input string tag);
    @(posedge CLK);
    if (RESET) begin
      model_reset();
    end else begin
      m_valid = 0;
      m_done  = 0;
      if (!m_run) begin
        if (SEED_VALID) begin
          if (SEED_DATA == 32'd0) begin
            m_err = 1;
            if (SEED_SEL) m_b = SEED_B; else m_a = SEED_A;
          end else begin
            if (SEED_SEL) m_b = SEED_DATA; else m_a = SEED_DATA;
          end
        end
        if (START && !STOP) begin
          m_run = 1; m_len = int'(BURST_LEN); m_cnt = 0;
        end
      end else if (STOP) begin
        m_run = 0;
      end else if (EN) begin
        m_bita = m_a[31];
        m_bitb = m_b[31];
        m_a = lfsr_next(m_a, TAPS_A);
        m_b = lfsr_next(m_b, TAPS_B);
        m_valid = 1;
        m_cnt = (m_cnt + 1) % 65536;
        if (m_len != 0 && m_cnt == m_len) begin
          m_done = 1;
          m_run  = 0;
        end
      end
    end
    #1;
    chk({tag, ".BIT_A"},      32'(BIT_A),      32'(m_bita));
    chk({tag, ".BIT_B"},      32'(BIT_B),      32'(m_bitb));
    chk({tag, ".BIT_VALID"},  32'(BIT_VALID),  32'(m_valid));
    chk({tag, ".DONE"},       32'(DONE),       32'(m_done));
    chk({tag, ".BUSY"},       32'(BUSY),       32'(m_run));
    chk({tag, ".SEED_READY"}, 32'(SEED_READY), 32'(!m_run));
    chk({tag, ".SEED_ERR"},   32'(SEED_ERR),   32'(m_err));
  endtask

  task automatic quiet();
    RESET = 0; START = 0; STOP = 0; EN = 0; SEED_VALID = 0; SEED_SEL = 0;
    BURST_LEN = '0; SEED_DATA = '0;
  endtask

  initial begin
    int nv, done_at, busy_after, ndone;
    logic [31:0] first_a;
    quiet();
    model_reset();
    RESET = 1;
    step("reset");
    step("reset");
    chk("reset_ready", 32'(SEED_READY), 32'd1);
    chk("reset_busy",  32'(BUSY),       32'd0);
    RESET = 0;

    // SEED_A=1 shifts zeros out of the MSB for the first 31 advances
    BURST_LEN = 16'd8; START = 1; EN = 1;
    step("burst8_start");
    START = 0;
    nv = 0; done_at = -1; busy_after = -1; ndone = 0; first_a = 0;
    for (int i = 0; i < 12; i++) begin
      step("burst8");
      if (done_at >= 0 && busy_after < 0) busy_after = int'(BUSY);
      if (BIT_VALID) begin nv++; first_a = first_a | 32'(BIT_A); end
      if (DONE) begin done_at = nv; ndone++; end
    end
    chk("burst8_count",      32'(nv),         32'd8);
    chk("burst8_done_on_8",  32'(done_at),    32'd8);
    chk("burst8_done_once",  32'(ndone),      32'd1);
    chk("burst8_busy_after", 32'(busy_after), 32'd0);
    chk("burst8_bita_zero",  first_a,         32'd0);

    // EN toggling with a 3-bit burst
    BURST_LEN = 16'd3; START = 1; EN = 0;
    step("en_start");
    START = 0;
    nv = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      EN = (i % 2 == 0);
      step("en_toggle");
      if (BIT_VALID) nv++;
      if (DONE) done_at = nv;
    end
    EN = 0;
    chk("en_toggle_count", 32'(nv),      32'd3);
    chk("en_toggle_done",  32'(done_at), 32'd3);

    // Zero seed to B: default substituted, sticky error
    SEED_VALID = 1; SEED_SEL = 1; SEED_DATA = 32'd0;
    step("seed_zero");
    SEED_VALID = 0;
    chk("seed_zero_err", 32'(SEED_ERR), 32'd1);
    step("seed_idle");

    // Seed + START same cycle: run uses the new seed
    SEED_VALID = 1; SEED_SEL = 0; SEED_DATA = 32'hF000_0000; START = 1; EN = 1;
    BURST_LEN = 16'd4;
    step("seed_start");
    SEED_VALID = 0; START = 0;
    step("seed_start_run");
    chk("seed_start_bita", 32'(BIT_A), 32'd1);
    for (int i = 0; i < 5; i++) step("seed_start_run");

    // Free-running; seed write while running refused
    BURST_LEN = 16'd0; START = 1; EN = 1;
    step("free_start");
    START = 0;
    SEED_VALID = 1; SEED_SEL = 1; SEED_DATA = 32'h1234_5678;
    for (int i = 0; i < 20; i++) step("free_seed_in_run");
    chk("run_seed_ready", 32'(SEED_READY), 32'd0);
    SEED_VALID = 0;

    // STOP with EN=1 in RUN: no advance, idle next cycle
    STOP = 1;
    step("stop_run");
    chk("stop_no_valid", 32'(BIT_VALID), 32'd0);
    chk("stop_idle",     32'(BUSY),      32'd0);
    // START+STOP in IDLE: stay idle
    START = 1;
    step("start_stop_idle");
    chk("start_stop_busy", 32'(BUSY), 32'd0);
    START = 0; STOP = 0;
    step("stop_idle");

    // RESET mid-burst
    BURST_LEN = 16'd50; START = 1; EN = 1;
    step("rst_burst_start");
    START = 0;
    for (int i = 0; i < 5; i++) step("rst_burst");
    RESET = 1;
    step("rst_mid");
    chk("rst_mid_valid", 32'(BIT_VALID), 32'd0);
    chk("rst_mid_err",   32'(SEED_ERR),  32'd0);
    RESET = 0;
    EN = 0;
    step("rst_after");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      RESET      = ($urandom_range(0, 199) == 0);
      START      = ($urandom_range(0, 9) == 0);
      STOP       = ($urandom_range(0, 29) == 0);
      EN         = ($urandom_range(0, 3) != 0);
      BURST_LEN  = CNT_W'($urandom_range(0, 20));
      SEED_VALID = ($urandom_range(0, 5) == 0);
      SEED_SEL   = 1'($urandom_range(0, 1));
      SEED_DATA  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
